// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam int DEFAULT_TIMEOUT = 15;

    // Wide enough to hold TIMEOUT itself, so the counter can saturate there.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_wdog_counter.sv
// Watchdog for outstanding memory accesses: clearable, saturating counter.
// expired is high on the last BUSY cycle allowed before an abort.
module mem_wdog_counter
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int CW = cnt_width(TIMEOUT)
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This cycle's increment would reach TIMEOUT.
    assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between decoder strobes and a handshaked data memory.
// Optional MEM_ALIGN_CHK_EN: misaligned requests abort instead of being word-aligned.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          readmem,
    input  logic          writemem,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          buserr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_d, state_q;
    logic          mem_req_d, mem_req_q;
    logic          mem_we_d, mem_we_q;
    logic [AW-1:0] mem_addr_d, mem_addr_q;
    logic [DW-1:0] mem_wdata_d, mem_wdata_q;
    logic [DW-1:0] rdata_d, rdata_q;
    logic          rvalid_d, rvalid_q;
    logic          buserr_d, buserr_q;

    logic          strobe;
    logic          misaligned;
    logic [AW-1:0] addr_eff;
    logic          expired;

    assign strobe = readmem | writemem;

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned = (addr[1:0] != 2'b00);
    assign addr_eff   = addr;
`else
    assign misaligned = 1'b0;
    assign addr_eff   = addr & ~AW'(3);
`endif

    mem_wdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clock   (clock),
        .reset   (reset),
        .clr     (state_q == IDLE),
        .en      ((state_q == BUSY) && !mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        buserr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // A simultaneous load+store is treated as a store.
                if (strobe) begin
                    mem_we_d    = writemem;
                    mem_addr_d  = addr_eff;
                    mem_wdata_d = wdata;
                    if (misaligned) begin
                        state_d  = ERR;
                        buserr_d = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        state_d   = BUSY;
                        mem_req_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Ack wins over a watchdog expiry in the same cycle.
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    rvalid_d  = !mem_we_q;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (expired) begin
                    state_d   = ERR;
                    mem_req_d = 1'b0;
                    buserr_d  = 1'b1;
                    rdata_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            buserr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            buserr_q    <= buserr_d;
        end
    end

    // Strobes in DONE/ERR belong to the departing instruction, so no stall there.
    assign stall     = ((state_q == IDLE) && strobe) || (state_q == BUSY);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign buserr    = buserr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboarded directed bench for mem_access_ctrl: responses (rvalid/buserr)
// are queued at issue time and checked by an independent monitor.
module tb_mem_access_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic          readmem, writemem;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          rvalid, buserr;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    mem_access_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .readmem   (readmem),
        .writemem  (writemem),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .buserr    (buserr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic          is_err;
        logic [DW-1:0] data;
        int            at;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   c0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_rsp(input logic is_err, input logic [DW-1:0] data, input int at);
        rsp_t r;
        r.is_err = is_err;
        r.data   = data;
        r.at     = at;
        exp_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every rvalid/buserr pulse must match the oldest expected response.
    rsp_t e;
    always @(negedge clock) begin
        if (!reset && (rvalid || buserr)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rvalid=%b buserr=%b rdata=%h want none (cycle %0d)",
                         rvalid, buserr, rdata, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_buserr", 64'(buserr), 64'(e.is_err));
                chk("rsp_rvalid", 64'(rvalid), 64'(!e.is_err));
                chk("rsp_rdata", 64'(rdata), 64'(e.data));
                chk("rsp_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; readmem = 1'b0; writemem = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step(); step(); #1;
        chk("rst_mem_req", 64'(mem_req), 0);
        chk("rst_mem_we", 64'(mem_we), 0);
        chk("rst_rvalid", 64'(rvalid), 0);
        chk("rst_buserr", 64'(buserr), 0);
        chk("rst_rdata", 64'(rdata), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_mem_wdata", 64'(mem_wdata), 0);
        chk("rst_stall", 64'(stall), 0);
        step(); reset = 1'b0;
        step();

        // Load, ack at cycle 3
        step(); readmem = 1'b1; addr = 32'h100; c0 = cyc;
        push_rsp(1'b0, 32'hDEADBEEF, c0 + 4);
        #1 chk("ld_stall_c0", 64'(stall), 1);
        step(); readmem = 1'b0; addr = '0;
        #1 chk("ld_mem_req_c1", 64'(mem_req), 1);
        chk("ld_mem_we_c1", 64'(mem_we), 0);
        chk("ld_mem_addr_c1", 64'(mem_addr), 64'h100);
        chk("ld_stall_c1", 64'(stall), 1);
        step(); #1 chk("ld_stall_c2", 64'(stall), 1);
        step(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1 chk("ld_stall_c3", 64'(stall), 1);
        step(); mem_ack = 1'b0; mem_rdata = '0;
        #1 chk("ld_stall_c4", 64'(stall), 0);
        chk("ld_mem_req_c4", 64'(mem_req), 0);
        step(); #1 chk("ld_rdata_hold", 64'(rdata), 64'hDEADBEEF);

        // Store, ack at cycle 1
        step(); writemem = 1'b1; addr = 32'h40; wdata = 32'h12345678;
        #1 chk("st_stall_c0", 64'(stall), 1);
        step(); writemem = 1'b0; addr = '0; wdata = '0; mem_ack = 1'b1;
        #1 chk("st_mem_we_c1", 64'(mem_we), 1);
        chk("st_mem_wdata_c1", 64'(mem_wdata), 64'h12345678);
        chk("st_mem_req_c1", 64'(mem_req), 1);
        step(); mem_ack = 1'b0;
        #1 chk("st_stall_c2", 64'(stall), 0);
        chk("st_rdata_kept", 64'(rdata), 64'hDEADBEEF);
        step();

        // Timeout: no ack
        step(); readmem = 1'b1; addr = 32'h200; c0 = cyc;
        push_rsp(1'b1, '0, c0 + TO + 1);
        for (int i = 1; i <= TO; i++) begin
            step(); readmem = 1'b0; addr = '0;
            #1 chk("to_mem_req_busy", 64'(mem_req), 1);
        end
        step(); #1 chk("to_mem_req_err", 64'(mem_req), 0);
        chk("to_stall_err", 64'(stall), 0);
        chk("to_rdata_zero", 64'(rdata), 0);
        step();

        // Ack on the timeout cycle
        step(); readmem = 1'b1; addr = 32'h300; c0 = cyc;
        push_rsp(1'b0, 32'hCAFEF00D, c0 + TO + 1);
        for (int i = 1; i < TO; i++) begin
            step(); readmem = 1'b0; addr = '0;
        end
        step(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1 chk("ato_mem_req_c15", 64'(mem_req), 1);
        step(); mem_ack = 1'b0; mem_rdata = '0;
        #1 chk("ato_stall_c16", 64'(stall), 0);
        step();

        // Both strobes: a single store
        step(); readmem = 1'b1; writemem = 1'b1; addr = 32'h80; wdata = 32'hA5A5A5A5;
        step(); readmem = 1'b0; writemem = 1'b0; addr = '0; wdata = '0; mem_ack = 1'b1;
        #1 chk("both_mem_we", 64'(mem_we), 1);
        chk("both_mem_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
        chk("both_mem_addr", 64'(mem_addr), 64'h80);
        step(); mem_ack = 1'b0;
        #1 chk("both_stall_done", 64'(stall), 0);
        step(); #1 chk("both_mem_req_idle", 64'(mem_req), 0);

        // Reset during a load, then a late ack
        step(); readmem = 1'b1; addr = 32'h500;
        step(); readmem = 1'b0; addr = '0;
        #1 chk("rm_mem_req_c1", 64'(mem_req), 1);
        step(); reset = 1'b1;
        step(); reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1 chk("rm_mem_req_c3", 64'(mem_req), 0);
        chk("rm_stall_c3", 64'(stall), 0);
        chk("rm_rdata_c3", 64'(rdata), 0);
        step(); mem_ack = 1'b0; mem_rdata = '0;
        #1 chk("rm_rvalid_c4", 64'(rvalid), 0);
        chk("rm_mem_req_c4", 64'(mem_req), 0);
        chk("rm_rdata_c4", 64'(rdata), 0);
        step();

`ifdef MEM_ALIGN_CHK_EN
        step(); readmem = 1'b1; addr = 32'h102; c0 = cyc;
        push_rsp(1'b1, '0, c0 + 1);
        #1 chk("al_stall_c0", 64'(stall), 1);
        step(); readmem = 1'b0; addr = '0;
        #1 chk("al_mem_req_c1", 64'(mem_req), 0);
        chk("al_stall_c1", 64'(stall), 0);
        step(); #1 chk("al_mem_req_c2", 64'(mem_req), 0);
`else
        step(); readmem = 1'b1; addr = 32'h102; c0 = cyc;
        push_rsp(1'b0, 32'h11223344, c0 + 2);
        step(); readmem = 1'b0; addr = '0; mem_ack = 1'b1; mem_rdata = 32'h11223344;
        #1 chk("al_mem_addr_c1", 64'(mem_addr), 64'h100);
        chk("al_mem_req_c1", 64'(mem_req), 1);
        step(); mem_ack = 1'b0; mem_rdata = '0;
        #1 chk("al_stall_c2", 64'(stall), 0);
`endif

        repeat (3) step();
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Data-memory access sequencer between the decoder's `readmem`/`writemem` strobes and a handshaked data memory. It latches one load or store per instruction, drives the memory request until acknowledged, stalls the pipeline meanwhile, and returns read data with a one-cycle valid pulse. A watchdog aborts accesses the memory never acknowledges.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `TIMEOUT`, 15, max BUSY cycles without `mem_ack` before abort; legal range ≥1.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `readmem` in 1: load request from the control decoder.
- `writemem` in 1: store request from the control decoder.
- `addr` in AW: effective address from the ALU.
- `wdata` in DW: store data (rt).
- `stall` out 1: freeze the pipeline.
- `rdata` out DW: load result.
- `rvalid` out 1: one-cycle pulse when `rdata` is valid.
- `buserr` out 1: one-cycle pulse when an access is aborted.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_ack` in 1: memory completion.
- `mem_rdata` in DW: memory read data, valid with `mem_ack`.

## Operation
- States: IDLE, BUSY, DONE, ERR.
- IDLE:
  - `readmem|writemem` high → latch `addr`, `wdata`, `we=writemem`, clear the counter, go to BUSY.
  - Both strobes high → treated as a store; the read is dropped.
- BUSY:
  - `mem_req`=1; `mem_we`/`mem_addr`/`mem_wdata` come from the latched values and are held stable.
  - `mem_ack`=1 → if a read, capture `mem_rdata` into `rdata`; go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT → go to ERR.
  - `mem_ack` in the same cycle the counter reaches TIMEOUT → ack wins, go to DONE.
- DONE:
  - `rvalid`=1 for reads only.
  - Strobes ignored, because they belong to the departing instruction. Go to IDLE.
- ERR: `buserr`=1, `rdata` forced to 0, `rvalid`=0, go to IDLE.
- `mem_ack` outside BUSY is ignored.
- `stall` = (IDLE & (`readmem|writemem`)) | BUSY. Combinational; low in DONE and ERR so the pipeline advances.
- `rdata` holds its last value until the next load completes or an abort occurs.
- Counter width is $clog2(TIMEOUT+1) and it saturates; it never wraps.
- Reset values: state IDLE; `mem_req`, `mem_we`, `rvalid`, `buserr` = 0; `rdata`, `mem_addr`, `mem_wdata`, counter = 0.

## Timing
- Request seen in IDLE at cycle 0 → `mem_req` high from cycle 1.
- `mem_ack` at cycle k (k≥1) → DONE at k+1, with `stall` low and `rvalid` high at k+1.
- Minimum access: 2 stall cycles (cycles 0 and 1).
- No ack → `mem_req` stays high for cycles 1..TIMEOUT; ERR at TIMEOUT+1.
- Back-to-back accesses: the next instruction's strobe is first seen in IDLE at k+2.
- Reset asserted mid-access: at that edge all outputs take their reset values and `mem_req` drops; a later `mem_ack` is ignored.

## Configuration
- `MEM_ALIGN_CHK_EN` defined: in IDLE, a request with `addr[1:0]`≠00 skips BUSY and goes directly to ERR (`buserr` pulse at cycle 1, `mem_req` never asserted). The stall lasts 1 cycle.
- Undefined: no check; `mem_addr[1:0]` is forced to 00 and the access proceeds normally.

## Structure
- Package `mem_ctrl_pkg`:
  - state enum (IDLE/BUSY/DONE/ERR);
  - default TIMEOUT constant;
  - helper function for the counter width.
- Sub-module `mem_wdog_counter`:
  - clear/enable/saturating counter with a `expired` output;
  - parameterised by TIMEOUT.

## Test plan
- Load: `readmem`=1, `addr`=0x100, ack at cycle 3 with `mem_rdata`=0xDEADBEEF → `stall` high cycles 0–3; `rvalid`=1 and `rdata`=0xDEADBEEF at cycle 4.
- Store: `writemem`=1, `addr`=0x40, `wdata`=0x12345678, ack at cycle 1 → `mem_we`=1 and `mem_wdata`=0x12345678 at cycle 1; `rvalid` stays 0; `stall` low at cycle 2.
- Timeout: load with no ack, TIMEOUT=15 → `mem_req` high cycles 1–15; `buserr` pulse at 16; `rdata`=0.
- Ack on the timeout cycle: ack at cycle 15 → DONE at 16, no `buserr`.
- Both strobes high → a single write issued; then reset at cycle 2 of a second access → `mem_req`=0 at cycle 3 and a late ack is ignored.
- With `MEM_ALIGN_CHK_EN`: load at `addr`=0x102 → no `mem_req`, `buserr` at cycle 1. Without it: `mem_addr`=0x100.
